// File: rtl/gray_rx_decoder.sv
// gray_rx_decoder
//
// Receives a Gray-coded value from a free-running source that is asynchronous
// to clk. The value is synchronised, converted to binary and flagged if it
// arrived through an illegal multi-bit Gray step. It is then offered to a
// consumer through a valid/ready handshake. A one-entry pending register
// absorbs one change while the consumer stalls. Further changes overwrite the
// pending entry, and each overwrite is counted in a saturating drop counter.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   g_in       in   WIDTH-bit Gray code, asynchronous to clk
//   out_ready  in   consumer accepts b_out while out_valid is high
//   out_valid  out  b_out/b_err hold an unconsumed decoded value
//   b_out      out  WIDTH-bit binary equivalent of the captured Gray value
//   b_err      out  the value in b_out followed an illegal multi-bit step
//   drop_cnt   out  8-bit saturating count of pending values overwritten

module gray_rx_decoder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] g_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] b_out,
  output logic             b_err,
  output logic [7:0]       drop_cnt
);

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    FULL      = 2'd1,
    FULL_PEND = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] s1, s2, s3;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] step_diff;
  logic             change;
  logic             step_err;
  logic [WIDTH-1:0] p_bin;
  logic             p_err;

  logic             load_out_new;
  logic             load_out_pend;
  logic             load_pend;
  logic             bump_drop;

  // s1/s2 form the two-flop synchroniser. s3 holds the previous synchronised
  // value, so that changes can be detected and step sizes measured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= g_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Each binary bit is the parity of this Gray bit and all bits above it.
  // Writing it as a shifted reduction avoids a self-referencing chain on bin.
  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(s2 >> i);
    end
  end

  // A legal Gray step flips exactly one bit. More than one set bit in the
  // difference is detected by clearing the lowest set bit and testing for zero.
  assign step_diff = s2 ^ s3;
  assign change    = (step_diff != '0);
  assign step_err  = ((step_diff & (step_diff - WIDTH'(1))) != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // In FULL_PEND with out_ready high, the pending entry moves to the output.
  // This frees the pending slot, so a simultaneous change is not a drop.
  always_comb begin
    state_nxt     = state;
    load_out_new  = 1'b0;
    load_out_pend = 1'b0;
    load_pend     = 1'b0;
    bump_drop     = 1'b0;
    case (state)
      EMPTY: begin
        if (change) begin
          load_out_new = 1'b1;
          state_nxt    = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          if (change) begin
            load_out_new = 1'b1;
          end else begin
            state_nxt = EMPTY;
          end
        end else if (change) begin
          load_pend = 1'b1;
          state_nxt = FULL_PEND;
        end
      end
      FULL_PEND: begin
        if (out_ready) begin
          load_out_pend = 1'b1;
          if (change) begin
            load_pend = 1'b1;
          end else begin
            state_nxt = FULL;
          end
        end else if (change) begin
          load_pend = 1'b1;
          bump_drop = 1'b1;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_out    <= '0;
      b_err    <= 1'b0;
      p_bin    <= '0;
      p_err    <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      if (load_out_new) begin
        b_out <= bin;
        b_err <= step_err;
      end else if (load_out_pend) begin
        b_out <= p_bin;
        b_err <= p_err;
      end
      if (load_pend) begin
        p_bin <= bin;
        p_err <= step_err;
      end
      if (bump_drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  assign out_valid = (state != EMPTY);

endmodule

// File: tb/tb_gray_rx_decoder.sv
// tb_gray_rx_decoder
//
// Self-checking bench for gray_rx_decoder with WIDTH=4. A behavioural model
// treats the output stage as a two-entry queue. A consumed head is popped, a
// decoded change is appended, and a change that finds the queue full replaces
// the tail and counts a drop. Outputs are compared on every falling edge.
// Directed scenarios are followed by randomized traffic.

module tb_gray_rx_decoder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] g_in = '0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [W-1:0] b_out;
  logic         b_err;
  logic [7:0]   drop_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  gray_rx_decoder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .g_in      (g_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .b_out     (b_out),
    .b_err     (b_err),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] bin;
    logic         err;
  } item_t;

  // seen[0] is the newest sample of g_in. seen[1] is the value the decoder
  // sees. seen[2] is the value it compares against.
  logic [W-1:0] seen [3];
  item_t        q [$];
  int           m_drop = 0;

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int sh = 1; sh < W; sh++) b = b ^ (g >> sh);
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    item_t it;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) seen[i] = '0;
      q.delete();
      m_drop = 0;
    end else begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (seen[1] != seen[2]) begin
        it.bin = gray2bin(seen[1]);
        it.err = ($countones(seen[1] ^ seen[2]) > 1);
        if (q.size() < 2) begin
          q.push_back(it);
        end else begin
          q[1] = it;
          if (m_drop < 255) m_drop++;
        end
      end
      seen[2] = seen[1];
      seen[1] = seen[0];
      seen[0] = g_in;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("valid", {15'd0, out_valid}, {15'd0, q.size() > 0});
      if (q.size() > 0) begin
        checkOutput("b_out", {12'd0, b_out}, {12'd0, q[0].bin});
        checkOutput("b_err", {15'd0, b_err}, {15'd0, q[0].err});
      end
      checkOutput("drop_cnt", {8'd0, drop_cnt}, m_drop[15:0]);
    end
  end

  // Drives g_in and out_ready just after a falling edge. The values are then
  // held for n clock cycles.
  task automatic applyStimulus(input logic [W-1:0] g, input logic rdy, input int n);
    @(negedge clk);
    g_in      = g;
    out_ready = rdy;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] gnext;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    rst_n  = 1'b1;

    // Idle input after reset produces nothing.
    applyStimulus(4'b0000, 1'b1, 20);
    checkOutput("idle_valid", {15'd0, out_valid}, 16'd0);
    checkOutput("idle_drop", {8'd0, drop_cnt}, 16'd0);

    // Latency of a single change with the consumer ready.
    @(negedge clk);
    g_in = 4'b0001;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("lat_k", {15'd0, out_valid}, 16'd0);
    @(negedge clk);
    checkOutput("lat_k1", {15'd0, out_valid}, 16'd0);
    @(negedge clk);
    checkOutput("lat_k2_valid", {15'd0, out_valid}, 16'd1);
    checkOutput("lat_k2_bout", {12'd0, b_out}, 16'd1);
    checkOutput("lat_k2_berr", {15'd0, b_err}, 16'd0);
    @(negedge clk);
    checkOutput("lat_k3_valid", {15'd0, out_valid}, 16'd0);

    applyStimulus(4'b0011, 1'b1, 5);
    applyStimulus(4'b0001, 1'b1, 5);
    applyStimulus(4'b0111, 1'b1, 5);
    applyStimulus(4'b0000, 1'b1, 5);
    applyStimulus(4'b1000, 1'b1, 5);
    applyStimulus(4'b0000, 1'b1, 5);

    // Stall with three changes: output, pending, then one overwrite.
    applyStimulus(4'b0001, 1'b0, 4);
    applyStimulus(4'b0011, 1'b0, 4);
    applyStimulus(4'b0010, 1'b0, 4);
    checkOutput("stall_bout", {12'd0, b_out}, 16'd1);
    checkOutput("stall_drop", {8'd0, drop_cnt}, 16'd1);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("drain_bout", {12'd0, b_out}, 16'd3);
    checkOutput("drain_valid", {15'd0, out_valid}, 16'd1);
    @(negedge clk);
    checkOutput("drain_empty", {15'd0, out_valid}, 16'd0);

    // Saturate the drop counter.
    for (int i = 0; i < 300; i++) begin
      applyStimulus((i % 2 == 0) ? 4'b0011 : 4'b0010, 1'b0, 2);
    end
    repeat (3) @(negedge clk);
    checkOutput("sat_drop", {8'd0, drop_cnt}, 16'd255);

    // Asynchronous reset while FULL_PEND.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", {15'd0, out_valid}, 16'd0);
    checkOutput("arst_bout", {12'd0, b_out}, 16'd0);
    checkOutput("arst_drop", {8'd0, drop_cnt}, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b0010, 1'b1, 6);

    // Randomized traffic, mostly single-bit steps with occasional jumps.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 4) == 0) gnext = W'($urandom);
      else gnext = g_in ^ W'(1 << $urandom_range(0, W - 1));
      applyStimulus(gnext, ($urandom_range(0, 2) != 0), $urandom_range(1, 4));
    end
    applyStimulus(g_in, 1'b1, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
